efpga_config_sequencer: RTL
===========================

Name: efpga_config_sequencer

Overview:
Consumes the 32-bit configuration word stream (word + write strobe) produced by the USB bridge stage and turns it into eFPGA frame writes. It searches for a sync word and then parses repeating records of one header word plus ROWS data words. Data words are forwarded row by row, and each record ends with a one-hot column commit strobe. A desync word ends the session. The block sits between the USB/UART bridge and the fabric configuration chain.

Parameters:
NUM_COLUMNS, 16, number of fabric columns (1..256); sets the width of frame_strobe_o
ROWS, 16, data words per frame record (>=1)
SYNC_WORD, 32'hFAB0_FAB1, word that opens a configuration session
DESYNC_WORD, 32'hFAB0_FAB0, word that closes a session when it arrives in the header position

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
write_data_i  in  32  configuration word from upstream
write_strobe_i  in  1  single-cycle qualifier for write_data_i; may assert every cycle
frame_data_o  out  32  current row data word
row_index_o  out  clog2(ROWS) (min 1)  row index of frame_data_o
frame_data_valid_o  out  1  one-cycle pulse per forwarded data word
frame_strobe_o  out  NUM_COLUMNS  one-hot column commit pulse
busy_o  out  1  high while in HEADER or DATA
done_o  out  1  sticky; set by desync
error_o  out  1  sticky; set by an out-of-range column
column_o  out  8  column index latched from the current header

Behaviour:
- Clock and reset: one clock, clk_i. reset_n_i is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; row counter 0.
- States: IDLE, HEADER, DATA. Transitions happen only on cycles where write_strobe_i=1. The block has no backpressure, so every strobed word must be accepted.
- IDLE:
  - word==SYNC_WORD -> HEADER; clear done_o and error_o.
  - Any other word is ignored.
- HEADER:
  - word==DESYNC_WORD -> IDLE; set done_o.
  - word==SYNC_WORD -> stay in HEADER (re-sync, no effect).
  - Otherwise the column is word[7:0]:
    - column >= NUM_COLUMNS -> IDLE; set error_o; no strobe.
    - Else latch column_o, clear the row counter, go to DATA.
  - word[31:8] is reserved and ignored.
- DATA:
  - Every strobed word is data, including words equal to SYNC_WORD or DESYNC_WORD.
  - Registered outputs, latency 1: frame_data_o=word, row_index_o=counter, frame_data_valid_o=1 for one cycle.
  - Row counter increments. When counter==ROWS-1: counter wraps to 0, state returns to HEADER, and a commit is scheduled.
- Commit: frame_strobe_o[column_o] pulses for exactly one cycle, the cycle after the last frame_data_valid_o of the record. This is latency 2 from the last input strobe. No dead cycle is required: a header word strobed in the cycle right after the last data word is accepted normally.
- frame_data_o and row_index_o hold their last value when frame_data_valid_o=0.
- busy_o is registered and equals (state != IDLE) on the following cycle.
- Reset mid-record: everything is cleared; a partially received frame is never committed.
- Simultaneous events: none are possible beyond the above, since there is a single input port.

Test Plan:
- Full record: reset, strobe 0xFAB0FAB1, header 0x00000003, then 16 data words 0x1000+i back-to-back -> 16 frame_data_valid_o pulses with row_index_o 0..15 and data 0x1000..0x100F; frame_strobe_o=16'h0008 for one cycle, one cycle after the last valid; busy_o=1.
- Pre-sync garbage: strobe 0xDEADBEEF and 0xFAB0FAB0 before sync -> no outputs change; done_o=0; state stays IDLE.
- Back-to-back records: sync, header 5 + 16 words, and header 6 with no idle cycle in between -> strobes 16'h0020 then 16'h0040; 32 valid pulses; no word dropped.
- Bad column: sync, header 0x00000010 (NUM_COLUMNS=16) -> error_o=1, busy_o=0, no strobe; a new sync clears error_o.
- Desync and in-data sync values: sync, header 0, data containing 0xFAB0FAB0 at row 2 -> forwarded as data; after the commit, header 0xFAB0FAB0 -> done_o=1, IDLE.
- Reset mid-record: assert reset_n_i after 7 data words -> all outputs 0 immediately; no frame_strobe_o ever pulses; after release, a new full record works.

Source files
------------

// File: rtl/efpga_config_sequencer.sv
// Configuration word parser: waits for a sync word, then turns header + ROWS
// data-word records into row writes followed by a one-hot column commit.
module efpga_config_sequencer #(
  parameter int          NUM_COLUMNS = 16,
  parameter int          ROWS        = 16,
  parameter logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0,
  localparam int         RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [31:0]            write_data_i,
  input  logic                   write_strobe_i,
  output logic [31:0]            frame_data_o,
  output logic [RW-1:0]          row_index_o,
  output logic                   frame_data_valid_o,
  output logic [NUM_COLUMNS-1:0] frame_strobe_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [7:0]             column_o
);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t                   state_q, state_d;
  logic [RW-1:0]            row_q, row_d;
  logic [31:0]              data_q, data_d;
  logic [RW-1:0]            ridx_q, ridx_d;
  logic                     valid_q, valid_d;
  logic                     commit_q, commit_d;
  logic [NUM_COLUMNS-1:0]   strobe_q, strobe_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [7:0]               col_q, col_d;
  logic                     col_bad;

  assign col_bad = ({1'b0, write_data_i[7:0]} >= 9'(NUM_COLUMNS));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      row_q    <= '0;
      data_q   <= '0;
      ridx_q   <= '0;
      valid_q  <= 1'b0;
      commit_q <= 1'b0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      data_q   <= data_d;
      ridx_q   <= ridx_d;
      valid_q  <= valid_d;
      commit_q <= commit_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      col_q    <= col_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    data_d   = data_q;
    ridx_d   = ridx_q;
    valid_d  = 1'b0;
    commit_d = 1'b0;
    done_d   = done_q;
    error_d  = error_q;
    col_d    = col_q;
    // Commit uses the column of the record just finished; a header accepted in
    // the same cycle only updates col_q at this edge, so it cannot interfere.
    strobe_d = commit_q ? (NUM_COLUMNS'(1) << col_q) : '0;
    if (write_strobe_i) begin
      case (state_q)
        IDLE: begin
          if (write_data_i == SYNC_WORD) begin
            state_d = HEADER;
            done_d  = 1'b0;
            error_d = 1'b0;
          end
        end
        HEADER: begin
          if (write_data_i == DESYNC_WORD) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (write_data_i == SYNC_WORD) begin
            state_d = HEADER;
          end else if (col_bad) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            col_d   = write_data_i[7:0];
            row_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          data_d  = write_data_i;
          ridx_d  = row_q;
          valid_d = 1'b1;
          if (row_q == RW'(ROWS - 1)) begin
            row_d    = '0;
            state_d  = HEADER;
            commit_d = 1'b1;
          end else begin
            row_d = RW'(row_q + 1'b1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign frame_data_o       = data_q;
  assign row_index_o        = ridx_q;
  assign frame_data_valid_o = valid_q;
  assign frame_strobe_o     = strobe_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign error_o            = error_q;
  assign column_o           = col_q;

endmodule
